// File: rtl/ch_measure_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------------------+
// | ch_measure_ctrl                                                                          |
// | Equivalent-time capture: ramps the comparator threshold per strobe delay code and emits |
// | one (time, voltage) point when the comparator reports signal < threshold.               |
// | Revision: 1.0                                                                            |
// +-----------------------------------------------------------------------------------------+
module ch_measure_ctrl #(
   parameter int TH_W     = 16,
   parameter int DC_W     = 10,
   parameter int SYNC_LEN = 2
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            run_i,
   input  logic            stb_i,
   input  logic            cmp_out_i,
   output logic [TH_W-1:0] threshold_o,
   output logic            threshold_wre_o,
   input  logic            threshold_rdy_i,
   input  logic [TH_W-1:0] threshold_delta_i,
   input  logic [DC_W-1:0] d_code_delta_i,
   output logic [DC_W-1:0] d_code_o,
   output logic            point_rdy_o,
   output logic [TH_W-1:0] point_v_o,
   output logic [DC_W-1:0] point_t_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SET_DAC   = 3'd1,
      S_WAIT_RDY_LO = 3'd2,
      S_WAIT_RDY_HI = 3'd3,
      S_WAIT_STB  = 3'd4,
      S_SAMPLE    = 3'd5,
      S_NEXT      = 3'd6,
      S_DONE      = 3'd7
   } state_t;

   localparam logic [TH_W-1:0] TH_MAX = {TH_W{1'b1}};
   localparam logic [DC_W-1:0] DC_MAX = {DC_W{1'b1}};
   localparam logic [TH_W-1:0] TH_ONE = {{(TH_W-1){1'b0}}, 1'b1};
   localparam logic [DC_W-1:0] DC_ONE = {{(DC_W-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [TH_W-1:0]       thr_q, thr_d;
   logic [DC_W-1:0]       dcode_q, dcode_d;
   logic [TH_W-1:0]       pv_q, pv_d;
   logic [DC_W-1:0]       pt_q, pt_d;
   logic                  prdy_q, prdy_d;
   logic                  armed_q, armed_d;
   logic [SYNC_LEN-1:0]   stb_sync_q, stb_sync_d;
   logic [SYNC_LEN-1:0]   cmp_sync_q, cmp_sync_d;
   logic [SYNC_LEN-1:0]   rdy_sync_q, rdy_sync_d;

   logic                  stb_s, cmp_s, rdy_s;
   logic [TH_W-1:0]       th_step;
   logic [DC_W-1:0]       dc_step;
   logic [TH_W:0]         thr_sum;
   logic [DC_W:0]         dc_sum;
   logic [TH_W-1:0]       thr_inc;
   logic [DC_W-1:0]       dc_inc;

   assign stb_s = stb_sync_q[SYNC_LEN-1];
   assign cmp_s = cmp_sync_q[SYNC_LEN-1];
   assign rdy_s = rdy_sync_q[SYNC_LEN-1];

   // Zero steps would stall the sweep, so they behave as a step of one.
   assign th_step = (threshold_delta_i == '0) ? TH_ONE : threshold_delta_i;
   assign dc_step = (d_code_delta_i == '0) ? DC_ONE : d_code_delta_i;
   assign thr_sum = {1'b0, thr_q} + {1'b0, th_step};
   assign dc_sum  = {1'b0, dcode_q} + {1'b0, dc_step};
   assign thr_inc = thr_sum[TH_W] ? TH_MAX : thr_sum[TH_W-1:0];
   assign dc_inc  = dc_sum[DC_W] ? DC_MAX : dc_sum[DC_W-1:0];

   always_comb begin
      state_d    = state_q;
      thr_d      = thr_q;
      dcode_d    = dcode_q;
      pv_d       = pv_q;
      pt_d       = pt_q;
      prdy_d     = 1'b0;
      armed_d    = armed_q;
      stb_sync_d = {stb_sync_q[SYNC_LEN-2:0], stb_i};
      cmp_sync_d = {cmp_sync_q[SYNC_LEN-2:0], cmp_out_i};
      rdy_sync_d = {rdy_sync_q[SYNC_LEN-2:0], threshold_rdy_i};

      if (state_q != S_IDLE && !run_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run_i) begin
                  dcode_d = '0;
                  thr_d   = '0;
                  state_d = S_SET_DAC;
               end
            end
            S_SET_DAC:     state_d = S_WAIT_RDY_LO;
            S_WAIT_RDY_LO: if (!rdy_s) state_d = S_WAIT_RDY_HI;
            S_WAIT_RDY_HI: begin
               if (rdy_s) begin
                  armed_d = 1'b0;
                  state_d = S_WAIT_STB;
               end
            end
            S_WAIT_STB: begin
               // A strobe already high on entry must fall before its rising edge counts.
               if (armed_q && stb_s) state_d = S_SAMPLE;
               else if (!stb_s)      armed_d = 1'b1;
            end
            S_SAMPLE: begin
               if (cmp_s && thr_q != TH_MAX) begin
                  thr_d   = thr_inc;
                  state_d = S_SET_DAC;
               end else begin
                  pv_d    = thr_q;
                  pt_d    = dcode_q;
                  prdy_d  = 1'b1;
                  state_d = S_NEXT;
               end
            end
            S_NEXT: begin
               if (dcode_q == DC_MAX) begin
                  state_d = S_DONE;
               end else begin
                  dcode_d = dc_inc;
                  thr_d   = '0;
                  state_d = S_SET_DAC;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         state_q    <= S_IDLE;
         thr_q      <= '0;
         dcode_q    <= '0;
         pv_q       <= '0;
         pt_q       <= '0;
         prdy_q     <= 1'b0;
         armed_q    <= 1'b0;
         stb_sync_q <= '0;
         cmp_sync_q <= '0;
         rdy_sync_q <= '0;
      end else begin
         state_q    <= state_d;
         thr_q      <= thr_d;
         dcode_q    <= dcode_d;
         pv_q       <= pv_d;
         pt_q       <= pt_d;
         prdy_q     <= prdy_d;
         armed_q    <= armed_d;
         stb_sync_q <= stb_sync_d;
         cmp_sync_q <= cmp_sync_d;
         rdy_sync_q <= rdy_sync_d;
      end
   end

   assign threshold_o     = thr_q;
   assign threshold_wre_o = (state_q == S_SET_DAC) && run_i;
   assign d_code_o        = dcode_q;
   assign point_rdy_o     = prdy_q;
   assign point_v_o       = pv_q;
   assign point_t_o       = pt_q;

endmodule
`default_nettype wire

// File: tb/tb_ch_measure_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------------------+
// | tb_ch_measure_ctrl                                                                       |
// | Directed bench with DAC, strobe and latched-comparator models around ch_measure_ctrl.   |
// | Revision: 1.0                                                                            |
// +-----------------------------------------------------------------------------------------+
module tb_ch_measure_ctrl;

   logic        clk_i = 1'b0;
   logic        arst_i, run_i, stb_i, cmp_out_i, threshold_rdy_i;
   logic [15:0] threshold_o, threshold_delta_i, point_v_o;
   logic        threshold_wre_o, point_rdy_o;
   logic [9:0]  d_code_delta_i, d_code_o, point_t_o;

   logic [16:0] sig;
   int          errors = 0;
   int          checks = 0;
   int          early_wre = 0;
   int          double_wre = 0;
   int          double_prdy = 0;
   logic        dac_busy = 1'b0;
   int          rdy_cnt = 0;
   logic [15:0] wr_q[$];
   logic [9:0]  pt_q[$];
   logic [15:0] pv_q[$];

   ch_measure_ctrl #(.TH_W(16), .DC_W(10), .SYNC_LEN(2)) dut (
      .clk_i(clk_i), .arst_i(arst_i), .run_i(run_i), .stb_i(stb_i), .cmp_out_i(cmp_out_i),
      .threshold_o(threshold_o), .threshold_wre_o(threshold_wre_o),
      .threshold_rdy_i(threshold_rdy_i), .threshold_delta_i(threshold_delta_i),
      .d_code_delta_i(d_code_delta_i), .d_code_o(d_code_o), .point_rdy_o(point_rdy_o),
      .point_v_o(point_v_o), .point_t_o(point_t_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      stb_i = 1'b0;
      forever begin
         repeat (2) @(posedge clk_i);
         #2 stb_i = ~stb_i;
      end
   end

   // Comparator holds its decision from each strobe rising edge.
   initial begin
      cmp_out_i = 1'b0;
      forever begin
         @(posedge stb_i);
         cmp_out_i = (sig >= {1'b0, threshold_o});
      end
   end

   // DAC model plus output monitor; rdy drops on a write and returns 20 ns later.
   initial begin
      logic prev_wre, prev_prdy;
      prev_wre = 1'b0;
      prev_prdy = 1'b0;
      threshold_rdy_i = 1'b1;
      forever begin
         @(negedge clk_i);
         if (threshold_wre_o) begin
            wr_q.push_back(threshold_o);
            if (dac_busy) early_wre++;
            if (prev_wre) double_wre++;
            dac_busy = 1'b1;
            threshold_rdy_i = 1'b0;
            rdy_cnt = 2;
         end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) begin
               threshold_rdy_i = 1'b1;
               dac_busy = 1'b0;
            end
         end
         if (point_rdy_o) begin
            pt_q.push_back(point_t_o);
            pv_q.push_back(point_v_o);
            if (prev_prdy) double_prdy++;
         end
         prev_wre = threshold_wre_o;
         prev_prdy = point_rdy_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_points(input int n, input int budget, input string tag);
      int cyc = 0;
      while (pt_q.size() < n && cyc < budget) begin
         @(posedge clk_i);
         cyc++;
      end
      check(tag, pt_q.size(), n);
   endtask

   task automatic clear_logs();
      wr_q.delete();
      pt_q.delete();
      pv_q.delete();
   endtask

   task automatic start_run(input logic [16:0] s, input logic [15:0] td, input logic [9:0] dd);
      run_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      clear_logs();
      sig = s;
      threshold_delta_i = td;
      d_code_delta_i = dd;
      run_i = 1'b1;
   endtask

   initial begin
      int bad;
      int n;
      logic [9:0] t_exp[5];
      logic [15:0] sat_exp[5];
      t_exp = '{10'd0, 10'd300, 10'd600, 10'd900, 10'd1023};
      sat_exp = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF};

      arst_i = 1'b1;
      run_i = 1'b0;
      sig = '0;
      threshold_delta_i = 16'd1;
      d_code_delta_i = 10'd1;
      repeat (3) @(posedge clk_i);
      #1 arst_i = 1'b0;
      @(negedge clk_i);
      check("rst_threshold", threshold_o, 0);
      check("rst_wre", threshold_wre_o, 0);
      check("rst_dcode", d_code_o, 0);
      check("rst_point_rdy", point_rdy_o, 0);
      check("rst_point_v", point_v_o, 0);
      check("rst_point_t", point_t_o, 0);
      repeat (10) @(posedge clk_i);
      check("idle_no_wre", wr_q.size(), 0);

      // Full sweep: signal 1, unit steps -> thresholds 0,1,2 per code, v=2.
      start_run(17'd1, 16'd1, 10'd1);
      wait_points(1024, 70000, "sweep_timeout");
      repeat (40) @(posedge clk_i);
      @(negedge clk_i);
      check("sweep_points", pt_q.size(), 1024);
      check("sweep_wre_count", wr_q.size(), 3072);
      check("handshake_th0", wr_q[0], 0);
      check("handshake_th1", wr_q[1], 1);
      check("handshake_th2", wr_q[2], 2);
      check("handshake_th3_next_code", wr_q[3], 0);
      bad = 0;
      for (int i = 0; i < pt_q.size(); i++)
         if (pt_q[i] != i[9:0] || pv_q[i] != 16'd2) bad++;
      check("sweep_point_values", bad, 0);
      check("sweep_last_t", pt_q[pt_q.size()-1], 1023);
      check("sweep_dcode_final", d_code_o, 1023);
      check("early_wre", early_wre, 0);
      check("double_wre", double_wre, 0);
      check("double_point_rdy", double_prdy, 0);

      // Code step 300 with signal 100 -> t 0,300,600,900,1023, v=101.
      start_run(17'd100, 16'd1, 10'd300);
      wait_points(5, 20000, "step300_timeout");
      repeat (40) @(posedge clk_i);
      @(negedge clk_i);
      check("step300_points", pt_q.size(), 5);
      check("step300_wre_count", wr_q.size(), 510);
      for (int i = 0; i < 5; i++) begin
         check("step300_t", pt_q[i], t_exp[i]);
         check("step300_v", pv_q[i], 101);
      end
      check("step300_point_hold", point_v_o, 101);

      // Comparator stuck high, step 0x4000 -> saturates at FFFF.
      start_run(17'h10000, 16'h4000, 10'd300);
      wait_points(5, 5000, "sat_timeout");
      repeat (40) @(posedge clk_i);
      @(negedge clk_i);
      check("sat_wre_count", wr_q.size(), 25);
      for (int i = 0; i < 5; i++) check("sat_threshold", wr_q[i], sat_exp[i]);
      bad = 0;
      for (int i = 0; i < pt_q.size(); i++)
         if (pv_q[i] != 16'hFFFF || pt_q[i] != t_exp[i]) bad++;
      check("sat_point_values", bad, 0);

      // Zero deltas act as one for the threshold; code step 512 clamps to 1023.
      start_run(17'd1, 16'd0, 10'd512);
      wait_points(3, 3000, "zero_delta_timeout");
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);
      check("zd_points", pt_q.size(), 3);
      check("zd_t1", pt_q[1], 512);
      check("zd_t2", pt_q[2], 1023);
      check("zd_v2", pv_q[2], 2);

      // Abort mid-ramp, then rerun from t=0.
      start_run(17'd100, 16'd1, 10'd1);
      n = 0;
      while (wr_q.size() < 20 && n < 2000) begin
         @(posedge clk_i);
         n++;
      end
      check("abort_reach_ramp", wr_q.size() >= 20, 1);
      #1 run_i = 1'b0;
      n = wr_q.size();
      repeat (30) @(posedge clk_i);
      @(negedge clk_i);
      check("abort_no_wre", wr_q.size(), n);
      check("abort_no_point", pt_q.size(), 0);
      check("abort_dcode_kept", d_code_o, 0);
      start_run(17'd100, 16'd1, 10'd1);
      wait_points(1, 3000, "rerun_timeout");
      @(negedge clk_i);
      check("rerun_t", pt_q[0], 0);
      check("rerun_v", pv_q[0], 101);
      check("rerun_first_th", wr_q[0], 0);

      // Reset mid-sweep clears outputs; no restart while run_i stays low.
      repeat (5) @(posedge clk_i);
      #1;
      arst_i = 1'b1;
      run_i = 1'b0;
      @(posedge clk_i);
      #1 arst_i = 1'b0;
      @(negedge clk_i);
      check("midrst_threshold", threshold_o, 0);
      check("midrst_dcode", d_code_o, 0);
      check("midrst_point_v", point_v_o, 0);
      check("midrst_point_t", point_t_o, 0);
      n = wr_q.size();
      repeat (10) @(posedge clk_i);
      @(negedge clk_i);
      check("midrst_no_wre", wr_q.size(), n);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
